// File: rtl/shift_pkg.sv
// Shared definitions for the shift pipeline: the operation encoding carried with
// every operand through the stages.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally shifts by DIST under its own shift-amount bit
// and registers the result together with the sideband it travels with.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DIST  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  shift_op_t                in_op,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_sign,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_shamt,
    output shift_op_t                out_op,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_sign
);

    localparam int K = $clog2(DIST);

    logic [WIDTH-1:0] shifted;

    // SRA fills from the operand's original MSB, not the partially shifted data
    always_comb begin
        shifted = in_data;
        if (in_shamt[K]) begin
            case (in_op)
                SHIFT_SLL: shifted = in_data << DIST;
                SHIFT_SRL: shifted = in_data >> DIST;
                SHIFT_SRA: shifted = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
                SHIFT_ROL: shifted = {in_data[WIDTH-DIST-1:0], in_data[WIDTH-1:WIDTH-DIST]};
                default:   shifted = in_data;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_op    <= SHIFT_SLL;
            out_tag   <= '0;
            out_sign  <= 1'b0;
        end else if (enable) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_shamt <= in_shamt;
            out_op    <= in_op;
            out_tag   <= in_tag;
            out_sign  <= in_sign;
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Log-depth pipelined shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes and
// a global stall; one stage per shift-amount bit, LSB stage first.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    localparam int L = SHAMT_W;

    logic               valid_s [L+1];
    logic [WIDTH-1:0]   data_s  [L+1];
    logic [SHAMT_W-1:0] shamt_s [L+1];
    shift_op_t          op_s    [L+1];
    logic [TAG_W-1:0]   tag_s   [L+1];
    logic               sign_s  [L+1];
    logic               stall;

    // Index 0 is the input side; index L is the last stage register
    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign shamt_s[0] = in_shamt;
    assign op_s[0]    = shift_op_t'(in_op);
    assign tag_s[0]   = in_tag;
    assign sign_s[0]  = in_data[WIDTH-1];

    // A held result freezes every stage, bubbles included
    assign stall    = valid_s[L] & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < L; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .DIST  (1 << k)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .enable    (~stall),
            .in_valid  (valid_s[k]),
            .in_data   (data_s[k]),
            .in_shamt  (shamt_s[k]),
            .in_op     (op_s[k]),
            .in_tag    (tag_s[k]),
            .in_sign   (sign_s[k]),
            .out_valid (valid_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_shamt (shamt_s[k+1]),
            .out_op    (op_s[k+1]),
            .out_tag   (tag_s[k+1]),
            .out_sign  (sign_s[k+1])
        );
    end

    assign out_valid = valid_s[L];
    assign out_data  = data_s[L];
    assign out_tag   = tag_s[L];
    assign out_zero  = valid_s[L] && (data_s[L] == '0);

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; legal values are powers of two from 4 to 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL have localparam SHAMT_W = log2(WIDTH), giving shift-amount width and pipeline depth L.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, the operation on the in_* ports is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts an operation this cycle.
REQ-008 SHALL have port in_data, input, WIDTH, the operand.
REQ-009 SHALL have port in_shamt, input, SHAMT_W, the shift distance.
REQ-010 SHALL have port in_op, input, 2, the mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 SHALL have port in_tag, input, TAG_W, sideband returned unchanged with the result.
REQ-012 SHALL have port out_valid, output, 1, out_* ports hold a result.
REQ-013 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-014 SHALL have port out_data, output, WIDTH, the shifted result.
REQ-015 SHALL have port out_tag, output, TAG_W, the tag of the result.
REQ-016 SHALL have port out_zero, output, 1, high when out_valid and out_data equals 0.

Function
REQ-017 SHALL transfer an input when in_valid and in_ready are both high, and an output when out_valid and out_ready are both high.
REQ-018 SHALL implement L registered stages; stage k conditionally shifts by 2^k under in_shamt[k], LSB stage first.
REQ-019 SHALL, in each stage, carry data, the remaining shamt bits, op, tag and a valid bit.
REQ-020 SHALL have latency exactly L cycles from input transfer to out_valid when never stalled; with WIDTH=32 this is 5 cycles.
REQ-021 SHALL sustain throughput of one operation per cycle while out_ready stays high.
REQ-022 SHALL fill vacated bits per mode:
- SLL: zero fill at the LSB end.
- SRL: zero fill at the MSB end.
- SRA: fill with the original in_data[WIDTH-1], carried through the stages.
- ROL: bits rotate in from the opposite end.
REQ-023 SHALL pass the operand through unchanged at shift amount 0 in every mode.
REQ-024 SHALL use a global stall: when out_valid=1 and out_ready=0, every stage holds its contents.
REQ-025 SHALL drive in_ready = out_ready OR NOT out_valid, combinationally, with no dependence on in_valid.
REQ-026 SHALL let bubbles advance when not stalled; empty stages are not collapsed.
REQ-027 SHALL keep out_data, out_tag and out_zero stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, when an input and an output transfer occur in the same cycle, shift the whole pipeline by one with no loss or duplication.
REQ-029 SHALL treat in_shamt as always below WIDTH by construction; no out-of-range case exists.

Reset
REQ-030 SHALL, while reset is high at a clock edge, clear all stage valid bits, data, tag, op and shamt registers to 0.
REQ-031 SHALL hold these values after reset: out_valid=0, out_data=0, out_tag=0, out_zero=0, in_ready=1.
REQ-032 SHALL, on reset asserted mid-operation, discard all in-flight operations with none emerging afterwards.
REQ-033 SHALL ignore an input presented in the reset cycle.

Structure
REQ-034 SHALL take the op encoding (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL) and its 2-bit typedef from shared package shift_pkg.
REQ-035 SHALL build each stage from one sub-module, shift_stage, parametrised by WIDTH, TAG_W and distance DIST; it holds a stage register with enable and a synchronous clear.
REQ-036 SHALL instantiate shift_stage L times with a generate loop, using DIST = 2^k.

Verification (WIDTH=32, TAG_W=4)
REQ-037 SHALL check: SLL in_data=0x0000_0001, shamt=31, tag=3 -> out_data=0x8000_0000, tag=3, exactly 5 cycles later.
REQ-038 SHALL check: SRA 0x8000_0000 shamt=4 -> 0xF800_0000; SRL same operand -> 0x0800_0000; ROL 0x8000_0001 shamt=1 -> 0x0000_0003.
REQ-039 SHALL check: SRL 0x0000_00FF shamt=8 -> out_data=0, out_zero=1; shamt=0 in all four modes -> operand unchanged.
REQ-040 SHALL check: back-to-back stream, tags 0..15, random ops with out_ready=1 -> 16 results in order on 16 consecutive cycles, each matching the reference model.
REQ-041 SHALL check: out_ready=0 for 3 cycles with the pipe full -> in_ready=0, outputs frozen; on release, no result lost or duplicated.
REQ-042 SHALL check: reset asserted for one cycle with 3 operations in flight -> out_valid stays 0 until new inputs, then normal 5-cycle latency resumes.
